fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences program_counter for instruction fetch: drives its set/lock/address-enable controls,
//  requests instruction memory, captures returned words into a one-entry buffer toward the decoder.
//  Applies branch redirects, halt requests and a fetch timeout. Sits between program_counter,
//  instruction memory and decode.
// PARAMETERS
//  ADDR_W        16   PC / memory address width
//  DATA_W        16   instruction word width
//  MEM_WAIT_MAX  15   max consecutive FETCH cycles without i_mem_ready before ERR (>=1)
// PORTS
//  clk              in   1       system clock, rising edge
//  rst              in   1       asynchronous, active-high reset
//  o_pc_set_address out  ADDR_W  redirect target to PC (i_set_address)
//  o_pc_set_en      out  1       PC load strobe (i_set_en)
//  o_pc_lock        out  1       PC hold (i_lock); 0 = PC increments this edge
//  o_pc_address_en  out  1       PC address tri-state enable (i_address_en)
//  o_mem_req        out  1       instruction read request, address = PC on bus
//  i_mem_ready      in   1       read data valid this cycle for address presented this cycle
//  i_mem_rdata      in   DATA_W  read data
//  o_instr          out  DATA_W  buffered instruction
//  o_instr_valid    out  1       buffer full
//  i_instr_ready    in   1       decoder accepts o_instr this cycle
//  i_branch_valid   in   1       redirect request, single-cycle
//  i_branch_target  in   ADDR_W  redirect address
//  i_halt           in   1       level; stop fetching while high
//  o_halted         out  1       state==HALT
//  o_timeout        out  1       sticky fetch-timeout flag
// BEHAVIOUR
//  Reset (async): state=IDLE, o_instr_valid=0, o_instr=0, o_timeout=0, wait counter=0.
//   While rst high: o_pc_lock=1, o_pc_set_en=0, o_pc_address_en=0, o_mem_req=0.
//   Top level drives program_counter's active-low reset from !rst.
//  States: IDLE, FETCH, HOLD, HALT, ERR. Control outputs combinational from state and inputs.
//  Default every cycle: o_pc_lock=1, o_pc_set_en=0.
//  IDLE: one cycle, then FETCH (HALT if i_halt).
//  FETCH: o_pc_address_en=1, o_mem_req=1.
//   accept = i_mem_ready & (!o_instr_valid | i_instr_ready).
//   accept: o_instr<=i_mem_rdata, o_instr_valid<=1, o_pc_lock=0 (PC+1 on this edge); stay FETCH.
//   i_mem_ready & buffer full & !i_instr_ready: data dropped, PC locked, -> HOLD.
//   Drain without refill: i_instr_ready & !accept clears o_instr_valid.
//  HOLD: o_mem_req=0, o_pc_address_en=0; i_instr_ready clears o_instr_valid, -> FETCH next cycle.
//  Redirect (IDLE/FETCH/HOLD, highest priority): o_pc_set_en=1, o_pc_set_address=i_branch_target,
//   o_pc_lock=1; o_instr_valid<=0 (including a word offered the same cycle, even if
//   i_instr_ready); same-cycle memory data discarded; wait counter<=0; next FETCH (HALT if i_halt).
//   Ignored in HALT and ERR.
//  Halt: i_halt in IDLE/FETCH/HOLD -> HALT next edge. A same-cycle i_mem_ready capture is
//   completed first (PC increments once). Buffer retained. In HALT: o_mem_req=0,
//   o_pc_address_en=0, PC locked; decoder may still drain buffer. i_halt low -> FETCH.
//  Timeout: in FETCH with !i_mem_ready, counter+1; reset to 0 on i_mem_ready, on leaving FETCH,
//   and on redirect. Counter reaching MEM_WAIT_MAX -> ERR, o_timeout<=1.
//   ERR: all requests off, PC locked, exit only by rst.
//  Counter width $clog2(MEM_WAIT_MAX+1); saturates, never wraps. PC wrap 16'hFFFF->0 left to PC.
//  o_pc_set_address = i_branch_target always (only qualified by o_pc_set_en).
// STRUCTURE
//  Shared header macpu_defs.vh: state encodings (FS_IDLE..FS_ERR, 3 bits), ADDR_W/DATA_W defaults.
//  Sub-module fetch_wait_timer: saturating wait counter, inputs count/clear, output expired.
//  Top of block: one FSM always block, buffer register, combinational control decode.
// TESTING
//  1 Reset release, mem always ready, decoder always ready -> instr_valid from cycle 2;
//    PC 0,1,2,3 on consecutive edges; o_instr tracks mem data per address.
//  2 Decoder stalls 3 cycles with buffer full -> one extra word dropped, HOLD, PC frozen,
//    o_mem_req=0; on ready: drain, FETCH, refetch dropped address.
//  3 i_branch_valid target 16'h0040 while a word is accepted same cycle -> set_en pulse,
//    o_instr_valid=0 next cycle, next fetch address 16'h0040.
//  4 i_halt with i_mem_ready same cycle -> word captured, PC+1 once, o_halted=1, no mem_req;
//    branch during HALT ignored; i_halt low resumes at PC unchanged.
//  5 i_mem_ready held low MEM_WAIT_MAX cycles -> ERR, o_timeout=1 sticky; rst mid-ERR ->
//    all outputs at reset values, IDLE.
//  6 rst asserted mid-FETCH with buffer full -> o_instr_valid=0 and lock=1 immediately (async).

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
// State encoding is fixed at 3 bits so it stays stable across tools and debug dumps.
package fetch_sequencer_pkg;

  localparam int ADDR_W_DEF       = 16;
  localparam int DATA_W_DEF       = 16;
  localparam int MEM_WAIT_MAX_DEF = 15;

  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_FETCH = 3'd1,
    FS_HOLD  = 3'd2,
    FS_HALT  = 3'd3,
    FS_ERR   = 3'd4
  } fetch_state_e;

  // Width needed to hold 0..max_val; at least one bit.
  function automatic int wait_cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the PC control, instruction memory, decoder and branch/halt signals
// around the fetch sequencer; master is the sequencer side.
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0] o_pc_set_address;
  logic              o_pc_set_en;
  logic              o_pc_lock;
  logic              o_pc_address_en;
  logic              o_mem_req;
  logic              i_mem_ready;
  logic [DATA_W-1:0] i_mem_rdata;
  logic [DATA_W-1:0] o_instr;
  logic              o_instr_valid;
  logic              i_instr_ready;
  logic              i_branch_valid;
  logic [ADDR_W-1:0] i_branch_target;
  logic              i_halt;
  logic              o_halted;
  logic              o_timeout;

  modport master (
    output o_pc_set_address, o_pc_set_en, o_pc_lock, o_pc_address_en, o_mem_req,
    output o_instr, o_instr_valid, o_halted, o_timeout,
    input  i_mem_ready, i_mem_rdata, i_instr_ready, i_branch_valid, i_branch_target, i_halt
  );

  modport slave (
    input  o_pc_set_address, o_pc_set_en, o_pc_lock, o_pc_address_en, o_mem_req,
    input  o_instr, o_instr_valid, o_halted, o_timeout,
    output i_mem_ready, i_mem_rdata, i_instr_ready, i_branch_valid, i_branch_target, i_halt
  );

endinterface

// File: rtl/fetch_wait_timer.sv
// Saturating count of consecutive memory-wait cycles; expired flags that one
// more counted cycle reaches MAX_COUNT.
module fetch_wait_timer
  import fetch_sequencer_pkg::*;
#(
  parameter int MAX_COUNT = MEM_WAIT_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic count,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = wait_cnt_w(MAX_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_COUNT - 1);

  logic [CNT_W-1:0] cnt_r;

  // wait counter: clear wins, saturates at MAX_COUNT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (count && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r >= CNT_LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: steers program_counter, requests instruction memory and holds
// one fetched word for the decoder; handles redirects, halt and fetch timeout.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF
) (
  input logic               clk,
  input logic               rst,
  fetch_sequencer_if.master bus
);

  fetch_state_e      state_r;
  fetch_state_e      next_state_s;
  logic [DATA_W-1:0] instr_r;
  logic              instr_valid_r;
  logic              timeout_r;
  logic [ADDR_W-1:0] branch_target_s;

  logic redirect_s;
  logic accept_s;
  logic pc_lock_s;
  logic mem_req_s;
  logic wait_count_s;
  logic wait_clear_s;
  logic wait_expired_s;
  logic timeout_set_s;

  // Count only while genuinely waiting in FETCH; any exit or redirect restarts it.
  assign wait_count_s = (state_r == FS_FETCH) && !bus.i_mem_ready &&
                        !bus.i_branch_valid && !bus.i_halt;
  assign wait_clear_s = !wait_count_s;

  fetch_wait_timer #(.MAX_COUNT(MEM_WAIT_MAX)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .count   (wait_count_s),
    .clear   (wait_clear_s),
    .expired (wait_expired_s)
  );

  // next-state and control decode; redirect > halt > hold/timeout
  always_comb begin
    next_state_s = state_r;
    redirect_s   = 1'b0;
    accept_s     = 1'b0;
    pc_lock_s    = 1'b1;
    mem_req_s    = 1'b0;
    case (state_r)
      FS_IDLE: begin
        redirect_s   = bus.i_branch_valid;
        next_state_s = bus.i_halt ? FS_HALT : FS_FETCH;
      end
      FS_FETCH: begin
        mem_req_s  = 1'b1;
        redirect_s = bus.i_branch_valid;
        accept_s   = !bus.i_branch_valid && bus.i_mem_ready &&
                     (!instr_valid_r || bus.i_instr_ready);
        pc_lock_s  = !accept_s;
        if (bus.i_branch_valid || bus.i_halt) begin
          next_state_s = bus.i_halt ? FS_HALT : FS_FETCH;
        end else if (bus.i_mem_ready) begin
          next_state_s = accept_s ? FS_FETCH : FS_HOLD;
        end else begin
          next_state_s = wait_expired_s ? FS_ERR : FS_FETCH;
        end
      end
      FS_HOLD: begin
        redirect_s = bus.i_branch_valid;
        if (bus.i_branch_valid || bus.i_halt) begin
          next_state_s = bus.i_halt ? FS_HALT : FS_FETCH;
        end else begin
          next_state_s = bus.i_instr_ready ? FS_FETCH : FS_HOLD;
        end
      end
      FS_HALT: begin
        next_state_s = bus.i_halt ? FS_HALT : FS_FETCH;
      end
      FS_ERR: begin
        next_state_s = FS_ERR;
      end
      default: begin
        next_state_s = FS_ERR;
      end
    endcase
  end

  assign timeout_set_s = (state_r == FS_FETCH) && (next_state_s == FS_ERR);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FS_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // one-entry instruction buffer; a redirect flushes even a same-cycle word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_r       <= '0;
      instr_valid_r <= 1'b0;
    end else if (redirect_s) begin
      instr_r       <= instr_r;
      instr_valid_r <= 1'b0;
    end else if (accept_s) begin
      instr_r       <= bus.i_mem_rdata;
      instr_valid_r <= 1'b1;
    end else if (bus.i_instr_ready) begin
      instr_r       <= instr_r;
      instr_valid_r <= 1'b0;
    end else begin
      instr_r       <= instr_r;
      instr_valid_r <= instr_valid_r;
    end
  end

  // sticky timeout flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= timeout_r | timeout_set_s;
    end
  end

  assign branch_target_s      = bus.i_branch_target;
  assign bus.o_pc_set_address = branch_target_s;
  assign bus.o_pc_set_en      = redirect_s & ~rst;
  assign bus.o_pc_lock        = pc_lock_s | rst;
  assign bus.o_pc_address_en  = mem_req_s & ~rst;
  assign bus.o_mem_req        = mem_req_s & ~rst;
  assign bus.o_instr          = instr_r;
  assign bus.o_instr_valid    = instr_valid_r;
  assign bus.o_halted         = (state_r == FS_HALT);
  assign bus.o_timeout        = timeout_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written corner sequences,
// then random traffic against a flag-based behavioural model.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int MAXW = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  fetch_sequencer_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  fetch_sequencer #(.ADDR_W(16), .DATA_W(16), .MEM_WAIT_MAX(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // program_counter stand-in driven by the sequencer's controls
  logic [15:0] pc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= 16'h0000;
    else if (bus.o_pc_set_en) pc_q <= bus.o_pc_set_address;
    else if (!bus.o_pc_lock) pc_q <= pc_q + 16'h0001;
  end
  assign bus.i_mem_rdata = mem_word(pc_q);

  typedef struct {
    bit rst, rdy, ird, br; logic [15:0] tgt; bit hlt;
    bit lock, set, req, aen, valid; logic [15:0] instr; bit halted; logic [15:0] pc;
  } vec_t;

  function automatic vec_t v(input bit r, rdy, ird, br, input logic [15:0] tgt, input bit hlt,
                             input bit lock, set, req, aen, valid, input logic [15:0] instr,
                             input bit halted, input logic [15:0] pc);
    vec_t x;
    x.rst = r; x.rdy = rdy; x.ird = ird; x.br = br; x.tgt = tgt; x.hlt = hlt;
    x.lock = lock; x.set = set; x.req = req; x.aen = aen; x.valid = valid;
    x.instr = instr; x.halted = halted; x.pc = pc;
    return x;
  endfunction

  task automatic chk1(input string nm, input bit act, input bit exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, rdy, ird, br, input logic [15:0] tgt, input bit hlt);
    rst = r; bus.i_mem_ready = rdy; bus.i_instr_ready = ird;
    bus.i_branch_valid = br; bus.i_branch_target = tgt; bus.i_halt = hlt;
  endtask

  task automatic check_outs(input string t, input bit lock, set, req, aen, valid,
                            input logic [15:0] instr, input bit halted, tmo, input logic [15:0] pc);
    chk1({t, " lock"}, bus.o_pc_lock, lock);
    chk1({t, " set_en"}, bus.o_pc_set_en, set);
    chk1({t, " mem_req"}, bus.o_mem_req, req);
    chk1({t, " addr_en"}, bus.o_pc_address_en, aen);
    chk1({t, " valid"}, bus.o_instr_valid, valid);
    chk16({t, " instr"}, bus.o_instr, instr);
    chk1({t, " halted"}, bus.o_halted, halted);
    chk1({t, " timeout"}, bus.o_timeout, tmo);
    chk16({t, " pc"}, pc_q, pc);
  endtask

  // behavioural model state
  bit m_started, m_hold, m_halt, m_err, m_valid, m_timeout;
  logic [15:0] m_instr, m_pc;
  int m_wait;

  task automatic model_reset();
    m_started = 1'b0; m_hold = 1'b0; m_halt = 1'b0; m_err = 1'b0;
    m_valid = 1'b0; m_timeout = 1'b0; m_instr = 16'h0000; m_pc = 16'h0000; m_wait = 0;
  endtask

  vec_t vt[17];

  initial begin
    bit fetching, redirect, take, r, rdy, ird, br, hlt_v;
    logic [15:0] tgt;
    int rdy_pct;

    // reset, streaming, decoder stall/HOLD, branch with same-cycle accept, halt
    vt[0]  = v(1'b1,1'b1,1'b1,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000);
    vt[1]  = v(1'b0,1'b1,1'b1,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000);
    vt[2]  = v(1'b0,1'b1,1'b1,1'b0,16'h0000,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,16'h0000,1'b0,16'h0000);
    vt[3]  = v(1'b0,1'b1,1'b1,1'b0,16'h0000,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b1,mem_word(16'h0000),1'b0,16'h0001);
    vt[4]  = v(1'b0,1'b1,1'b1,1'b0,16'h0000,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b1,mem_word(16'h0001),1'b0,16'h0002);
    vt[5]  = v(1'b0,1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b1,1'b1,1'b1,mem_word(16'h0002),1'b0,16'h0003);
    vt[6]  = v(1'b0,1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,mem_word(16'h0002),1'b0,16'h0003);
    vt[7]  = v(1'b0,1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,mem_word(16'h0002),1'b0,16'h0003);
    vt[8]  = v(1'b0,1'b1,1'b1,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,mem_word(16'h0002),1'b0,16'h0003);
    vt[9]  = v(1'b0,1'b1,1'b1,1'b0,16'h0000,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,mem_word(16'h0002),1'b0,16'h0003);
    vt[10] = v(1'b0,1'b1,1'b1,1'b1,16'h0040,1'b0, 1'b1,1'b1,1'b1,1'b1,1'b1,mem_word(16'h0003),1'b0,16'h0004);
    vt[11] = v(1'b0,1'b1,1'b1,1'b0,16'h0000,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,mem_word(16'h0003),1'b0,16'h0040);
    vt[12] = v(1'b0,1'b1,1'b1,1'b0,16'h0000,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b1,mem_word(16'h0040),1'b0,16'h0041);
    vt[13] = v(1'b0,1'b1,1'b0,1'b1,16'h0099,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b1,mem_word(16'h0041),1'b1,16'h0042);
    vt[14] = v(1'b0,1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,mem_word(16'h0041),1'b1,16'h0042);
    vt[15] = v(1'b0,1'b1,1'b1,1'b0,16'h0000,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b1,mem_word(16'h0041),1'b0,16'h0042);
    vt[16] = v(1'b0,1'b0,1'b1,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b1,1'b1,1'b1,mem_word(16'h0042),1'b0,16'h0043);

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].rst, vt[i].rdy, vt[i].ird, vt[i].br, vt[i].tgt, vt[i].hlt);
      @(negedge clk);
      check_outs($sformatf("row%0d", i), vt[i].lock, vt[i].set, vt[i].req, vt[i].aen,
                 vt[i].valid, vt[i].instr, vt[i].halted, 1'b0, vt[i].pc);
      @(posedge clk); #1;
    end

    // memory never ready: the MAXW-th waiting cycle drops into ERR
    for (int k = 2; k <= MAXW; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
      @(negedge clk);
      chk1($sformatf("wait%0d req", k), bus.o_mem_req, 1'b1);
      chk1($sformatf("wait%0d timeout", k), bus.o_timeout, 1'b0);
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0123, 1'b0);
    @(negedge clk);
    check_outs("err", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mem_word(16'h0042), 1'b0, 1'b1, 16'h0043);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("err sticky timeout", bus.o_timeout, 1'b1);
    chk16("err pc frozen", pc_q, 16'h0043);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    #1;
    check_outs("rst in err", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    @(posedge clk); #1;

    // async reset while FETCH holds a full buffer
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    chk1("idle req", bus.o_mem_req, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("fetch lock", bus.o_pc_lock, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    chk1("full before rst", bus.o_instr_valid, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    #1;
    check_outs("async rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    @(posedge clk); #1;

    // random traffic against the model
    model_reset();
    hlt_v = 1'b0;
    rdy_pct = 80;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) rdy_pct = ($urandom_range(3) == 0) ? 3 : 80;
      r   = (c < 2) || ($urandom_range(59) == 0);
      rdy = ($urandom_range(99) < rdy_pct);
      ird = ($urandom_range(99) < 70);
      br  = ($urandom_range(11) == 0);
      tgt = 16'($urandom);
      if ($urandom_range(15) == 0) hlt_v = !hlt_v;
      drive(r, rdy, ird, br, tgt, hlt_v);
      if (r) model_reset();
      @(negedge clk);
      fetching = m_started && !m_hold && !m_halt && !m_err;
      redirect = br && !m_halt && !m_err && !r;
      take     = fetching && !redirect && rdy && (!m_valid || ird);
      check_outs($sformatf("rnd%0d", c), !take, redirect, fetching, fetching, m_valid,
                 m_instr, m_halt, m_timeout, m_pc);
      chk16($sformatf("rnd%0d set_addr", c), bus.o_pc_set_address, tgt);
      if (!r) begin
        if (redirect) begin
          m_valid = 1'b0; m_pc = tgt; m_wait = 0;
          m_started = 1'b1; m_hold = 1'b0; m_halt = hlt_v;
        end else if (!m_started) begin
          m_started = 1'b1; m_halt = hlt_v;
        end else if (m_err) begin
          if (ird) m_valid = 1'b0;
        end else if (m_halt) begin
          if (ird) m_valid = 1'b0;
          if (!hlt_v) m_halt = 1'b0;
        end else if (m_hold) begin
          if (ird) m_valid = 1'b0;
          if (hlt_v) begin m_halt = 1'b1; m_hold = 1'b0; end
          else if (ird) m_hold = 1'b0;
        end else begin
          if (take) begin m_instr = mem_word(m_pc); m_valid = 1'b1; m_pc = m_pc + 16'h0001; end
          else if (ird) m_valid = 1'b0;
          if (hlt_v) begin m_halt = 1'b1; m_wait = 0; end
          else if (rdy) begin m_wait = 0; if (!take) m_hold = 1'b1; end
          else begin
            m_wait++;
            if (m_wait >= MAXW) begin m_err = 1'b1; m_timeout = 1'b1; m_wait = 0; end
          end
        end
      end
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
